// File: rtl/weight_stream_reader_pkg.sv
// Shared ANN constants for the weight-RAM read path: weight width, per-neuron
// weight count, derived address width and the reader FSM encoding.
package weight_stream_reader_pkg;

  localparam int unsigned ANN_DW    = 16;
  localparam int unsigned ANN_DEPTH = 28;
  localparam int unsigned ANN_AW    = $clog2(ANN_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } wsr_state_e;

endpackage

// File: rtl/weight_stream_reader_skid_fifo.sv
// Two-entry FIFO whose head is always a register, so the consumer never sees
// the RAM output directly; absorbs one stalled word plus one in-flight read.
module weight_skid_fifo #(
  parameter int unsigned W = 21
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;
  logic         pop_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign head_o  = head_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      case ({push_i, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q  <= push_data_i;
            count_q <= 2'd1;
          end else if (count_q == 2'd1) begin
            tail_q  <= push_data_i;
            count_q <= 2'd2;
          end
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the tail (if any) advances into the head.
          if (count_q == 2'd1) begin
            head_q <= push_data_i;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/weight_stream_reader.sv
// Read-side sequencer for one weight block RAM: sequential reads on START,
// presented as an indexed valid/ready stream through a 2-entry skid FIFO.
module weight_stream_reader
  import weight_stream_reader_pkg::*;
#(
  parameter int unsigned DEPTH = ANN_DEPTH,
  parameter int unsigned AW    = ANN_AW,
  parameter int unsigned DW    = ANN_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] BRAM_ADDR,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  output logic [DW-1:0] BRAM_DI,
  input  logic [DW-1:0] BRAM_DO,
  output logic [DW-1:0] W_DATA,
  output logic [AW-1:0] W_INDEX,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic          W_LAST
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  wsr_state_e    state_q;
  logic [AW-1:0] addr_q;
  logic          en_q;
  logic          busy_q;
  logic          done_q;

  logic [AW-1:0] addr_nxt;
  logic          pop;
  logic          credit;
  logic          issue;
  logic [1:0]    count;
  logic [AW+DW-1:0] head;

  assign BRAM_ADDR = addr_q;
  assign BRAM_EN   = en_q;
  assign BRAM_WE   = 1'b0;
  assign BRAM_DI   = '0;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

  assign W_INDEX = head[AW+DW-1:DW];
  assign W_DATA  = head[DW-1:0];
  assign W_LAST  = W_VALID && (W_INDEX == LAST_ADDR);

  assign pop      = W_VALID && W_READY;
  assign addr_nxt = (addr_q == LAST_ADDR) ? addr_q : addr_q + 1'b1;
  // en_q doubles as the in-flight flag: a read issued last cycle lands now.
  assign credit   = (({1'b0, count} + {2'b00, en_q}) - {2'b00, pop}) < 3'd2;

  always_comb begin
    issue = 1'b0;
    case (state_q)
      ST_IDLE:  issue = START;
      ST_FETCH: issue = credit;
      default:  issue = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q   <= issue;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            addr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= (LAST_ADDR == '0) ? ST_DRAIN : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (issue) begin
            addr_q <= addr_nxt;
            if (addr_nxt == LAST_ADDR) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && W_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  weight_skid_fifo #(
    .W (AW + DW)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (en_q),
    .push_data_i ({addr_q, BRAM_DO}),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (W_VALID),
    .count_o     (count)
  );

endmodule

// File: tb/tb_weight_stream_reader.sv
// Self-checking bench for weight_stream_reader: behavioural RAM plus a
// transaction-level model (issued/accepted word counts) checked every cycle.
module tb_weight_stream_reader;

  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          BUSY, DONE, BRAM_EN, BRAM_WE, W_VALID, W_LAST;
  logic          W_READY = 1'b0;
  logic [AW-1:0] BRAM_ADDR, W_INDEX;
  logic [DW-1:0] BRAM_DI, W_DATA;
  logic [DW-1:0] BRAM_DO = '0;

  weight_stream_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE),
    .BRAM_DI(BRAM_DI), .BRAM_DO(BRAM_DO), .W_DATA(W_DATA),
    .W_INDEX(W_INDEX), .W_VALID(W_VALID), .W_READY(W_READY), .W_LAST(W_LAST)
  );

  always #5 CLK = ~CLK;

  // RAM samples ADDR/EN on the falling edge inside the issue cycle.
  logic [DW-1:0] mem [DEPTH];
  always @(negedge CLK) if (BRAM_EN && int'(BRAM_ADDR) < DEPTH) BRAM_DO <= mem[BRAM_ADDR];

  int n_assert = 0, n_fail = 0;
  int issued = 0, accepted = 0, done_cnt = 0, cyc_n = 0;
  int start_cyc = 0, first_v = 0, done_cyc = 0;
  bit busy_m = 0, done_exp = 0, prev_stall = 0, last_done = 0, restart_on_done = 0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    check("rst_busy", BUSY, 0);     check("rst_done", DONE, 0);
    check("rst_en", BRAM_EN, 0);    check("rst_addr", BRAM_ADDR, 0);
    check("rst_we", BRAM_WE, 0);    check("rst_di", BRAM_DI, 0);
    check("rst_valid", W_VALID, 0); check("rst_last", W_LAST, 0);
    check("rst_data", W_DATA, 0);   check("rst_index", W_INDEX, 0);
  endtask

  // One clock: check outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic cyc(input bit rdy, input bit st_in, input bit rst);
    bit st;
    @(negedge CLK);
    cyc_n++;
    check("we", BRAM_WE, 0);
    check("di", BRAM_DI, 0);
    check("busy", BUSY, busy_m);
    check("done", DONE, done_exp);
    last_done = DONE;
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
    if (BRAM_EN) issued++;
    if (issued > 0) check("addr", BRAM_ADDR, issued - 1);
    check("credit", (issued - accepted <= 2), 1);
    if (W_VALID) begin
      if (first_v == 0) first_v = cyc_n;
      check("index", W_INDEX, accepted);
      check("data", W_DATA, mem[accepted % DEPTH]);
      check("last", W_LAST, accepted == DEPTH - 1);
    end else begin
      check("last_idle", W_LAST, 0);
    end
    if (prev_stall) begin
      check("stall_valid", W_VALID, 1);
      check("stall_data", W_DATA, prev_data);
    end
    st = st_in || (restart_on_done && DONE);
    RST = rst; START = st; W_READY = rdy;
    done_exp = 0;
    if (rst) begin
      issued = 0; accepted = 0; busy_m = 0; prev_stall = 0;
    end else begin
      if (W_VALID && rdy) begin
        accepted++;
        if (accepted == DEPTH) begin done_exp = 1; busy_m = 0; end
      end
      if (st && !BUSY) begin
        issued = 0; accepted = 0; busy_m = 1; start_cyc = cyc_n; first_v = 0;
      end
      prev_stall = W_VALID && !rdy;
    end
    prev_data = W_DATA;
  endtask

  // mode 0: ready high, 1: pattern 1,0,0,1, 2: random
  task automatic run(input int mode, input bit ign);
    bit pulsed = 0, rdy, st;
    last_done = 0;
    for (int i = 0; i < 400 && !last_done; i++) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((i % 4) == 0 || (i % 4) == 3)
                                             : 1'($urandom_range(0, 1));
      st = ign && !pulsed && accepted == 5;
      if (st) pulsed = 1;
      cyc(rdy, st, 0);
    end
    check("pass_completes", last_done, 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0100 + 16'(i);

    // Reset state
    cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 0);
    chk_reset();

    // Back-to-back pass
    done_cnt = 0;
    cyc(1, 1, 0);
    run(0, 0);
    check("b2b_first_word", first_v - start_cyc, 2);
    check("b2b_done_time", done_cyc - start_cyc, 30);
    check("b2b_dones", done_cnt, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    check("sat_en", BRAM_EN, 0);
    check("sat_addr", BRAM_ADDR, DEPTH - 1);

    // Backpressure pattern
    fill_random();
    done_cnt = 0;
    cyc(1, 1, 0);
    run(1, 0);
    check("bp_dones", done_cnt, 1);

    // Consumer stalled from start
    fill_random();
    cyc(0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    check("stall_reads", issued, 2);
    check("stall_head_valid", W_VALID, 1);
    check("stall_head_index", W_INDEX, 0);
    run(0, 0);

    // START ignored mid-pass, START in the DONE cycle restarts
    fill_random();
    done_cnt = 0;
    cyc(1, 1, 0);
    restart_on_done = 1;
    run(2, 1);
    restart_on_done = 0;
    check("ign_dones", done_cnt, 1);
    run(0, 0);
    check("restart_dones", done_cnt, 2);

    // Reset while the read of address 12 is in flight
    fill_random();
    cyc(1, 1, 0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0);
    cyc(1, 0, 1);
    check("pre_rst_en", BRAM_EN, 1);
    check("pre_rst_addr", BRAM_ADDR, 12);
    cyc(1, 0, 0);
    chk_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0);
      check("no_valid_after_rst", W_VALID, 0);
    end
    done_cnt = 0;
    cyc(1, 1, 0);
    run(2, 0);
    check("post_rst_dones", done_cnt, 1);

    // Random passes
    for (int p = 0; p < 2; p++) begin
      fill_random();
      cyc(1, 1, 0);
      run(2, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
